// File: rtl/dsp_bus_bridge.sv
// dsp_bus_bridge: decodes SNES cartridge-bus cycles into fixed-width DSPn
// register / data-RAM strobes and returns captured read data to the CPU bus.
module dsp_bus_bridge #(
  parameter int unsigned STROBE_LEN = 4,
  parameter int unsigned GAP_LEN    = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic [1:0]  MAP,
  input  logic [23:0] CA,
  input  logic        CPU_RD_N,
  input  logic        CPU_WR_N,
  input  logic [7:0]  CPU_DI,
  output logic [7:0]  CPU_DO,
  output logic        CPU_DO_VALID,
  output logic        BUSY,
  output logic        DSP_CS_N,
  output logic        DSP_RD_N,
  output logic        DSP_WR_N,
  output logic        DSP_A0,
  output logic [7:0]  DSP_DI,
  input  logic [7:0]  DSP_DO,
  output logic        DSP_DP_SEL,
  output logic [11:0] DSP_DP_ADDR
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BANK_W = 7;
  localparam int unsigned ADDR_W = 12;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;

  // CPU strobe history for falling-edge detection
  logic                rd_q, rd_qq, wr_q, wr_qq;

  // Access latched at the edge, used when the start is deferred by ENABLE=0
  logic                pend_q;
  logic                lat_rd_q;
  logic                lat_dp_q;
  logic                lat_a0_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [7:0]          lat_di_q;

  // Direction of the access in flight and early-release marker
  logic                dir_rd_q;
  logic                abort_q;

  // Address decode results for the current CPU address
  logic [BANK_W-1:0]   bank;
  logic                dec_reg;
  logic                dec_dp;
  logic                dec_a0;

  logic                rd_fall, wr_fall, one_low, start_edge;
  logic                go_rd, go_dp, go_a0;
  logic [ADDR_W-1:0]   go_addr;
  logic [7:0]          go_di;

  // CA[23] is a mirror bit and plays no part in the decode
  logic                unused_ca;
  assign unused_ca = CA[23];

  // Memory-map decode of the live CPU address
  always_comb begin
    bank    = CA[22:16];
    dec_reg = 1'b0;
    dec_dp  = 1'b0;
    dec_a0  = 1'b0;
    case (MAP)
      2'd0: begin
        if (bank[6:4] == 3'b011 && CA[15]) begin
          dec_reg = 1'b1;
          dec_a0  = CA[14];
        end
      end
      2'd1: begin
        if (bank[6:5] == 2'b00 && CA[15:13] == 3'b011) begin
          dec_reg = 1'b1;
          dec_a0  = CA[12];
        end
      end
      2'd2: begin
        if (CA[15:12] == 4'h0) begin
          if (bank[6:3] == 4'b1100) begin
            dec_reg = 1'b1;
            dec_a0  = CA[0];
          end else if (bank[6:3] == 4'b1101) begin
            dec_dp = 1'b1;
          end
        end
      end
      default: begin
        dec_reg = 1'b0;
      end
    endcase
  end

  // A start needs exactly one CPU strobe low, freshly fallen, on a decoded address
  assign rd_fall    = rd_qq & ~rd_q;
  assign wr_fall    = wr_qq & ~wr_q;
  assign one_low    = rd_q ^ wr_q;
  assign start_edge = (state_q == ST_IDLE) && !pend_q && one_low &&
                      (rd_fall || wr_fall) && (dec_reg || dec_dp);

  // Access parameters: live decode on an immediate start, latched copy otherwise
  assign go_rd   = pend_q ? lat_rd_q   : ~rd_q;
  assign go_dp   = pend_q ? lat_dp_q   : dec_dp;
  assign go_a0   = pend_q ? lat_a0_q   : dec_a0;
  assign go_addr = pend_q ? lat_addr_q : CA[11:0];
  assign go_di   = pend_q ? lat_di_q   : CPU_DI;

  // Access sequencer: edge capture, strobe timing, read capture
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_q         <= 1'b1;
      rd_qq        <= 1'b1;
      wr_q         <= 1'b1;
      wr_qq        <= 1'b1;
      pend_q       <= 1'b0;
      lat_rd_q     <= 1'b0;
      lat_dp_q     <= 1'b0;
      lat_a0_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_di_q     <= '0;
      dir_rd_q     <= 1'b0;
      abort_q      <= 1'b0;
      CPU_DO       <= '0;
      CPU_DO_VALID <= 1'b0;
      BUSY         <= 1'b0;
      DSP_CS_N     <= 1'b1;
      DSP_RD_N     <= 1'b1;
      DSP_WR_N     <= 1'b1;
      DSP_A0       <= 1'b0;
      DSP_DI       <= '0;
      DSP_DP_SEL   <= 1'b0;
      DSP_DP_ADDR  <= '0;
    end else begin
      rd_q  <= CPU_RD_N;
      rd_qq <= rd_q;
      wr_q  <= CPU_WR_N;
      wr_qq <= wr_q;

      if (start_edge) begin
        lat_rd_q   <= ~rd_q;
        lat_dp_q   <= dec_dp;
        lat_a0_q   <= dec_a0;
        lat_addr_q <= CA[11:0];
        lat_di_q   <= CPU_DI;
      end

      // An edge seen while stalled is held until ENABLE returns
      if (start_edge && !ENABLE) begin
        pend_q <= 1'b1;
      end

      // The bus mux must release as soon as the CPU ends its read
      if (CPU_DO_VALID && CPU_RD_N) begin
        CPU_DO_VALID <= 1'b0;
      end

      // A read released during the strobe never reports data
      if (state_q == ST_ASSERT && dir_rd_q && CPU_RD_N) begin
        abort_q <= 1'b1;
      end

      if (ENABLE) begin
        case (state_q)
          ST_IDLE: begin
            if (start_edge || pend_q) begin
              state_q     <= ST_ASSERT;
              cnt_q       <= '0;
              pend_q      <= 1'b0;
              abort_q     <= 1'b0;
              dir_rd_q    <= go_rd;
              BUSY        <= 1'b1;
              DSP_CS_N    <= go_dp;
              DSP_RD_N    <= ~go_rd;
              DSP_WR_N    <= go_rd;
              DSP_A0      <= go_a0;
              DSP_DP_SEL  <= go_dp;
              DSP_DP_ADDR <= go_addr;
              DSP_DI      <= go_di;
            end
          end
          ST_ASSERT: begin
            if (cnt_q == STROBE_LAST) begin
              state_q    <= ST_RELEASE;
              cnt_q      <= '0;
              DSP_CS_N   <= 1'b1;
              DSP_RD_N   <= 1'b1;
              DSP_WR_N   <= 1'b1;
              DSP_DP_SEL <= 1'b0;
              if (dir_rd_q && !abort_q && !CPU_RD_N) begin
                CPU_DO       <= DSP_DO;
                CPU_DO_VALID <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_RELEASE: begin
            if (cnt_q == GAP_LAST) begin
              state_q <= ST_WAIT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_WAIT: begin
            if (CPU_RD_N && CPU_WR_N) begin
              state_q <= ST_IDLE;
              BUSY    <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            BUSY    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_bus_bridge.sv
// Bench for dsp_bus_bridge: table of single accesses plus hand sequences
// for stalls, early release, ignored edges and mid-access reset.
module tb_dsp_bus_bridge;

  localparam int unsigned SL = 4;
  localparam int unsigned GL = 3;
  localparam int NV = 15;

  logic        CLK = 1'b0;
  logic        RST_N, ENABLE, CPU_RD_N, CPU_WR_N;
  logic [1:0]  MAP;
  logic [23:0] CA;
  logic [7:0]  CPU_DI, DSP_DO;
  logic [7:0]  CPU_DO, DSP_DI;
  logic        CPU_DO_VALID, BUSY, DSP_CS_N, DSP_RD_N, DSP_WR_N, DSP_A0, DSP_DP_SEL;
  logic [11:0] DSP_DP_ADDR;

  dsp_bus_bridge #(.STROBE_LEN(SL), .GAP_LEN(GL)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .MAP(MAP), .CA(CA),
    .CPU_RD_N(CPU_RD_N), .CPU_WR_N(CPU_WR_N), .CPU_DI(CPU_DI),
    .CPU_DO(CPU_DO), .CPU_DO_VALID(CPU_DO_VALID), .BUSY(BUSY),
    .DSP_CS_N(DSP_CS_N), .DSP_RD_N(DSP_RD_N), .DSP_WR_N(DSP_WR_N),
    .DSP_A0(DSP_A0), .DSP_DI(DSP_DI), .DSP_DO(DSP_DO),
    .DSP_DP_SEL(DSP_DP_SEL), .DSP_DP_ADDR(DSP_DP_ADDR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  map;
    logic [23:0] ca;
    logic        rd;
    logic [7:0]  di;
    logic [7:0]  dsp_do;
    logic        hit;
    logic        a0;
    logic        dp;
  } vec_t;

  typedef struct {
    logic        rd;
    logic        cs_n;
    logic        a0;
    logic        dp;
    logic [11:0] addr;
    logic [7:0]  di;
    int          len;
  } strb_t;

  vec_t        vecs [NV];
  strb_t       sq [$];
  logic [7:0]  rq [$];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (BUSY && k < bound) begin
      tick();
      k++;
    end
    chk("busy_clear_timeout", 32'(BUSY), 32'd0);
  endtask

  function automatic strb_t mk_strb(input logic rd, input logic dp, input logic a0,
                                    input logic [11:0] addr, input logic [7:0] di, input int len);
    strb_t s;
    s.rd = rd; s.cs_n = dp; s.a0 = a0; s.dp = dp; s.addr = addr; s.di = di; s.len = len;
    return s;
  endfunction

  // Strobe monitor: pops the expected access on each DSP strobe and checks it throughout
  strb_t cur;
  logic  have_cur = 1'b0;
  logic  in_strb  = 1'b0;
  logic  vld_prev = 1'b0;
  int    slen     = 0;

  task automatic mon_fields;
    chk("strobe_rd_n", 32'(DSP_RD_N), 32'(!cur.rd));
    chk("strobe_wr_n", 32'(DSP_WR_N), 32'(cur.rd));
    chk("strobe_cs_n", 32'(DSP_CS_N), 32'(cur.cs_n));
    chk("strobe_dp_sel", 32'(DSP_DP_SEL), 32'(cur.dp));
    if (!cur.cs_n) chk("strobe_a0", 32'(DSP_A0), 32'(cur.a0));
    if (cur.dp) chk("strobe_dp_addr", 32'(DSP_DP_ADDR), 32'(cur.addr));
    if (!cur.rd) chk("strobe_di", 32'(DSP_DI), 32'(cur.di));
  endtask

  always @(negedge CLK) begin
    if (!DSP_RD_N || !DSP_WR_N) begin
      if (!in_strb) begin
        in_strb = 1'b1;
        slen = 1;
        if (sq.size() == 0) begin
          have_cur = 1'b0;
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          cur = sq.pop_front();
          have_cur = 1'b1;
        end
      end else begin
        slen++;
      end
      if (have_cur) mon_fields();
    end else if (in_strb) begin
      in_strb = 1'b0;
      if (have_cur) chk("strobe_len", 32'(slen), 32'(cur.len));
      have_cur = 1'b0;
    end
    if (CPU_DO_VALID && !vld_prev) begin
      if (rq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else chk("cpu_do", 32'(CPU_DO), 32'(rq.pop_front()));
    end
    vld_prev = CPU_DO_VALID;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, 32'(DSP_CS_N), 32'd1);
    chk({tag, "_rd_n"}, 32'(DSP_RD_N), 32'd1);
    chk({tag, "_wr_n"}, 32'(DSP_WR_N), 32'd1);
    chk({tag, "_a0"}, 32'(DSP_A0), 32'd0);
    chk({tag, "_di"}, 32'(DSP_DI), 32'd0);
    chk({tag, "_dp_sel"}, 32'(DSP_DP_SEL), 32'd0);
    chk({tag, "_dp_addr"}, 32'(DSP_DP_ADDR), 32'd0);
    chk({tag, "_cpu_do"}, 32'(CPU_DO), 32'd0);
    chk({tag, "_valid"}, 32'(CPU_DO_VALID), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  // One access with ENABLE=1 and the CPU strobe released at edge+5
  task automatic run_vec(input vec_t v);
    tick();
    MAP = v.map; CA = v.ca; CPU_DI = v.di; DSP_DO = v.dsp_do;
    if (v.rd) CPU_RD_N = 1'b0; else CPU_WR_N = 1'b0;
    if (v.hit) sq.push_back(mk_strb(v.rd, v.dp, v.a0, v.ca[11:0], v.di, SL));
    if (v.hit && v.rd) rq.push_back(v.dsp_do);
    tick();
    chk("idle_at_edge", 32'(BUSY), 32'd0);
    tick();
    chk("busy_start", 32'(BUSY), 32'(v.hit));
    chk("strobe_start", 32'(v.rd ? DSP_RD_N : DSP_WR_N), 32'(!v.hit));
    repeat (3) tick();
    chk("valid_early", 32'(CPU_DO_VALID), 32'd0);
    tick();
    chk("valid", 32'(CPU_DO_VALID), 32'(v.hit && v.rd));
    chk("strobe_end", 32'(DSP_RD_N & DSP_WR_N), 32'd1);
    CPU_RD_N = 1'b1; CPU_WR_N = 1'b1;
    tick();
    chk("valid_clear", 32'(CPU_DO_VALID), 32'd0);
    if (v.hit && !v.dp) chk("hold_a0", 32'(DSP_A0), 32'(v.a0));
    if (v.hit && v.dp) chk("hold_dp_addr", 32'(DSP_DP_ADDR), 32'(v.ca[11:0]));
    tick();
    chk("busy_gap", 32'(BUSY), 32'(v.hit));
    wait_idle(20);
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  logic [13:0] snap, prev_snap;

  initial begin
    //          map   ca            rd    di     do     hit   a0    dp
    vecs[0]  = '{2'd0, 24'h308000, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, 24'h30C000, 1'b1, 8'h00, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{2'd1, 24'h006000, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'd1, 24'h1F7000, 1'b0, 8'hC3, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{2'd2, 24'h600001, 1'b1, 8'h00, 8'h11, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{2'd2, 24'h670000, 1'b0, 8'h22, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2'd2, 24'h6F0ABC, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{2'd1, 24'h008000, 1'b1, 8'h00, 8'h44, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'd3, 24'h306000, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'd0, 24'hB0C000, 1'b1, 8'h00, 8'h5E, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{2'd0, 24'h2F8000, 1'b0, 8'h66, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'd0, 24'h3F4000, 1'b1, 8'h00, 8'h12, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2'd2, 24'h601000, 1'b1, 8'h00, 8'h34, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{2'd2, 24'h700000, 1'b1, 8'h00, 8'h56, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{2'd0, 24'h3FFFFF, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0};

    RST_N = 1'b0; ENABLE = 1'b1; MAP = 2'd0; CA = '0;
    CPU_RD_N = 1'b1; CPU_WR_N = 1'b1; CPU_DI = '0; DSP_DO = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    RST_N = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // ENABLE alternating from the edge cycle: strobe spans 8 clocks, outputs frozen on stalls
    tick();
    ENABLE = 1'b0; MAP = 2'd0; CA = 24'h308000; CPU_DI = 8'hA5; CPU_WR_N = 1'b0;
    sq.push_back(mk_strb(1'b0, 1'b0, 1'b0, 12'h000, 8'hA5, 8));
    prev_snap = '0;
    for (int j = 1; j <= 18; j++) begin
      tick();
      snap = {DSP_WR_N, DSP_RD_N, DSP_CS_N, DSP_A0, DSP_DP_SEL, BUSY, DSP_DI};
      if (j >= 3 && (j % 2) == 1) chk("hold_when_disabled", 32'(snap), 32'(prev_snap));
      prev_snap = snap;
      ENABLE = ((j % 2) == 1);
      if (j == 12) CPU_WR_N = 1'b1;
    end
    ENABLE = 1'b1;
    wait_idle(20);
    repeat (2) tick();

    // Data-RAM read with DSP_DO changing every clock: capture takes the last strobe cycle
    tick();
    MAP = 2'd2; CA = 24'h680123; DSP_DO = 8'hA0; CPU_RD_N = 1'b0;
    sq.push_back(mk_strb(1'b1, 1'b1, 1'b0, 12'h123, 8'h00, SL));
    rq.push_back(8'hA5);
    for (int j = 1; j <= 5; j++) begin
      tick();
      DSP_DO = 8'hA0 + 8'(j);
    end
    tick();
    chk("dp_valid", 32'(CPU_DO_VALID), 32'd1);
    chk("dp_cpu_do", 32'(CPU_DO), 32'hA5);
    CPU_RD_N = 1'b1;
    wait_idle(20);
    repeat (2) tick();

    // CPU read released at edge+2: full DSP strobe, no valid
    tick();
    MAP = 2'd0; CA = 24'h30C000; DSP_DO = 8'h99; CPU_RD_N = 1'b0;
    sq.push_back(mk_strb(1'b1, 1'b0, 1'b1, 12'h000, 8'h00, SL));
    tick();
    tick();
    tick();
    CPU_RD_N = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("valid_after_early_release", 32'(CPU_DO_VALID), 32'd0);
    end
    wait_idle(20);
    repeat (2) tick();

    // Second CPU edge during RELEASE is ignored; WAIT_END holds until the strobe rises
    tick();
    MAP = 2'd0; CA = 24'h30C000; CPU_DI = 8'h3E; CPU_WR_N = 1'b0;
    sq.push_back(mk_strb(1'b0, 1'b0, 1'b1, 12'h000, 8'h3E, SL));
    repeat (6) tick();
    CPU_WR_N = 1'b1;
    tick();
    CPU_WR_N = 1'b0; CPU_DI = 8'h11;
    repeat (2) tick();
    chk("wait_end_busy", 32'(BUSY), 32'd1);
    repeat (3) tick();
    chk("wait_end_hold", 32'(BUSY), 32'd1);
    CPU_WR_N = 1'b1;
    wait_idle(20);
    repeat (8) tick();
    chk("no_second_access", 32'(BUSY), 32'd0);

    // Reset at edge+2: outputs back to reset values on the next clock
    tick();
    MAP = 2'd0; CA = 24'h30C000; CPU_DI = 8'h66; CPU_WR_N = 1'b0;
    sq.push_back(mk_strb(1'b0, 1'b0, 1'b1, 12'h000, 8'h66, 2));
    tick();
    tick();
    chk("pre_reset_strobe", 32'(DSP_WR_N), 32'd0);
    tick();
    RST_N = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    RST_N = 1'b1; CPU_WR_N = 1'b1;
    repeat (6) tick();
    chk("post_reset_idle", 32'(BUSY), 32'd0);

    chk("strobe_queue_empty", 32'(sq.size()), 32'd0);
    chk("read_queue_empty", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
